// File: rtl/dep_matrix_sched.sv
// dep_matrix_sched: dependency-matrix scheduler for BS instruction-buffer slots.
// Each slot holds a valid bit, an issued bit and a BS-bit dependency row.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   alloc_valid/idx/dep  one allocate per cycle into slot alloc_idx
//   cmp_valid/idx        NCMP completion ports, port p uses cmp_idx[p*IW +: IW]
//   issue_valid/idx      lowest-index ready slot offered to the consumer
//   issue_ready          consumer accepts the offered slot
//   ready_mask           valid & ~issued & no outstanding dependency
//   busy_mask            valid bits
//   alloc_err            one-cycle pulse after a rejected allocate
//   stall_cnt            cycles with busy slots but none ready
//   issue_cnt            accepted issue handshakes
//
// Optional feature: define IDT_PERF_EN to build the saturating perf
// counters; otherwise stall_cnt and issue_cnt are tied to zero.
module dep_matrix_sched #(
  parameter int BS    = 16,
  parameter int NCMP  = 2,
  parameter int CNT_W = 16,
  localparam int IW   = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  input  logic [IW-1:0]      alloc_idx,
  input  logic [BS-1:0]      alloc_dep,
  input  logic [NCMP-1:0]    cmp_valid,
  input  logic [NCMP*IW-1:0] cmp_idx,
  output logic               issue_valid,
  output logic [IW-1:0]      issue_idx,
  input  logic               issue_ready,
  output logic [BS-1:0]      ready_mask,
  output logic [BS-1:0]      busy_mask,
  output logic               alloc_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   issue_cnt
);

  logic [BS-1:0] valid_q;
  logic [BS-1:0] issued_q;
  logic [BS-1:0] dep_q [BS];
  logic          alloc_err_q;

  logic [BS-1:0] valid_d;
  logic [BS-1:0] issued_d;
  logic [BS-1:0] dep_d [BS];

  logic [BS-1:0] cmask;
  logic [BS-1:0] valid_pc;
  logic [BS-1:0] alloc_oh;
  logic [BS-1:0] row_new;
  logic [BS-1:0] issue_oh;
  logic          alloc_ok;
  logic          fire;
  logic [BS-1:0] rdy;
  logic [IW-1:0] pick;

  // Slots retired this cycle. Completions of free slots are ignored and
  // duplicate indices simply OR into the same bit.
  always_comb begin
    cmask = '0;
    for (int p = 0; p < NCMP; p++) begin
      for (int s = 0; s < BS; s++) begin
        if (cmp_valid[p] && valid_q[s] &&
            cmp_idx[p*IW +: IW] == IW'(s))
          cmask[s] = 1'b1;
      end
    end
  end

  assign valid_pc = valid_q & ~cmask;
  assign alloc_oh = BS'(1) << alloc_idx;
  assign alloc_ok = alloc_valid & ~valid_pc[alloc_idx];

  // Dependencies on free, just-completed or the slot itself are dropped.
  assign row_new = alloc_dep & valid_pc & ~alloc_oh;

  always_comb begin
    for (int i = 0; i < BS; i++)
      rdy[i] = valid_q[i] & ~issued_q[i] & ~(|dep_q[i]);
  end

  always_comb begin
    pick = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (rdy[i])
        pick = IW'(i);
    end
  end

  assign ready_mask  = rdy;
  assign busy_mask   = valid_q;
  assign issue_valid = |rdy;
  assign issue_idx   = pick;
  assign alloc_err   = alloc_err_q;

  assign fire     = issue_valid & issue_ready;
  assign issue_oh = fire ? (BS'(1) << pick) : '0;

  // Completion beats issue on the same slot; a fresh allocate always
  // starts unissued, so the issue mask is also filtered by alloc.
  always_comb begin
    valid_d  = valid_pc;
    issued_d = (issued_q | issue_oh) & ~cmask;
    for (int i = 0; i < BS; i++) begin
      dep_d[i] = dep_q[i] & ~cmask;
      if (cmask[i])
        dep_d[i] = '0;
    end
    if (alloc_ok) begin
      valid_d  = valid_d | alloc_oh;
      issued_d = issued_d & ~alloc_oh;
      for (int i = 0; i < BS; i++) begin
        if (alloc_idx == IW'(i))
          dep_d[i] = row_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      issued_q    <= '0;
      alloc_err_q <= 1'b0;
      for (int i = 0; i < BS; i++)
        dep_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      issued_q    <= issued_d;
      alloc_err_q <= alloc_valid & ~alloc_ok;
      for (int i = 0; i < BS; i++)
        dep_q[i] <= dep_d[i];
    end
  end

`ifdef IDT_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] iss_q;
  logic             stall;

  assign stall = (|valid_q) & ~(|rdy);

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      iss_q   <= '0;
    end else begin
      if (stall && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;
      if (fire && iss_q != {CNT_W{1'b1}})
        iss_q <= iss_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = iss_q;
`else
  assign stall_cnt = '0;
  assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_dep_matrix_sched.sv
// tb_dep_matrix_sched: directed bench for dep_matrix_sched.
// Linear stimulus with hand-computed expectations and immediate asserts.
module tb_dep_matrix_sched;

  localparam int BS    = 16;
  localparam int NCMP  = 2;
  localparam int CNT_W = 4;
  localparam int IW    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               alloc_valid;
  logic [IW-1:0]      alloc_idx;
  logic [BS-1:0]      alloc_dep;
  logic [NCMP-1:0]    cmp_valid;
  logic [NCMP*IW-1:0] cmp_idx;
  logic               issue_valid;
  logic [IW-1:0]      issue_idx;
  logic               issue_ready;
  logic [BS-1:0]      ready_mask;
  logic [BS-1:0]      busy_mask;
  logic               alloc_err;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   issue_cnt;

  int checks = 0;
  int errors = 0;

  dep_matrix_sched #(
    .BS(BS), .NCMP(NCMP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_dep(alloc_dep),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_ready(issue_ready),
    .ready_mask(ready_mask), .busy_mask(busy_mask),
    .alloc_err(alloc_err),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input int idx, input logic [BS-1:0] dep);
    alloc_valid = 1'b1;
    alloc_idx   = IW'(idx);
    alloc_dep   = dep;
    tick();
    alloc_valid = 1'b0;
    alloc_dep   = '0;
  endtask

  task automatic cmp(input logic [1:0] v, input int i0, input int i1);
    cmp_valid = v;
    cmp_idx   = {IW'(i1), IW'(i0)};
    tick();
    cmp_valid = '0;
  endtask

  // Expected perf values depend on the build configuration.
  function automatic logic [31:0] pc(input int v);
`ifdef IDT_PERF_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_idx = '0;
    alloc_dep = '0;
    cmp_valid = '0;
    cmp_idx = '0;
    issue_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy_mask, 0);
    chk("rst_ready", ready_mask, 0);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_iidx", issue_idx, 0);
    chk("rst_err", alloc_err, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_icnt", issue_cnt, 0);

    // T1: reset with five busy slots and same-cycle traffic
    for (int i = 0; i < 5; i++)
      alloc(i, '0);
    chk("t1_busy5", busy_mask, 32'h001F);
    rst = 1'b1;
    alloc_valid = 1'b1;
    alloc_idx = 4'd6;
    cmp_valid = 2'b01;
    cmp_idx = 8'h00;
    issue_ready = 1'b1;
    tick();
    rst = 1'b0;
    alloc_valid = 1'b0;
    cmp_valid = '0;
    issue_ready = 1'b0;
    chk("t1_busy", busy_mask, 0);
    chk("t1_ivalid", issue_valid, 0);
    chk("t1_err", alloc_err, 0);
    chk("t1_stall", stall_cnt, 0);
    chk("t1_icnt", issue_cnt, 0);

    // T2: single alloc, offer, accept
    alloc(3, '0);
    chk("t2_ready", ready_mask, 32'h0008);
    chk("t2_ivalid", issue_valid, 1);
    chk("t2_iidx", issue_idx, 3);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t2_ready_after", ready_mask, 0);
    chk("t2_busy_after", busy_mask, 32'h0008);
    chk("t2_icnt", issue_cnt, pc(1));
    cmp(2'b01, 3, 0);
    chk("t2_freed", busy_mask, 0);

    // T3: slot5 waits on slot2; completion on port 1 releases it
    alloc(2, '0);
    alloc(5, 16'h0004);
    chk("t3_blocked", ready_mask, 32'h0004);
    cmp(2'b10, 0, 2);
    chk("t3_ready5", ready_mask, 32'h0020);
    chk("t3_busy", busy_mask, 32'h0020);
    cmp(2'b11, 5, 5);
    chk("t3_dup_cmp", busy_mask, 0);
    chk("t3_err", alloc_err, 0);

    // T4: priority order 1, 4, 9
    alloc(1, '0);
    alloc(4, '0);
    alloc(9, '0);
    chk("t4_ready", ready_mask, 32'h0212);
    chk("t4_first", issue_idx, 1);
    tick();
    chk("t4_hold", issue_idx, 1);
    issue_ready = 1'b1;
    tick();
    chk("t4_second", issue_idx, 4);
    tick();
    chk("t4_third", issue_idx, 9);
    tick();
    chk("t4_none_v", issue_valid, 0);
    chk("t4_none_i", issue_idx, 0);
    tick();
    issue_ready = 1'b0;
    chk("t4_icnt", issue_cnt, pc(4));
    chk("t4_busy", busy_mask, 32'h0212);
    cmp(2'b11, 1, 4);
    cmp(2'b01, 9, 0);
    chk("t4_freed", busy_mask, 0);

    // T5: complete and reallocate slot 7 in one cycle
    alloc(7, '0);
    chk("t5_pre", ready_mask, 32'h0080);
    alloc_valid = 1'b1;
    alloc_idx = 4'd7;
    alloc_dep = 16'h0080;
    cmp_valid = 2'b01;
    cmp_idx = {4'd0, 4'd7};
    tick();
    alloc_valid = 1'b0;
    alloc_dep = '0;
    cmp_valid = '0;
    chk("t5_err", alloc_err, 0);
    chk("t5_busy", busy_mask, 32'h0080);
    chk("t5_ready", ready_mask, 32'h0080);
    cmp(2'b01, 7, 0);

    // T6: fill all slots behind an issued slot 0, then overflow
    alloc(0, '0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    for (int i = 1; i < BS; i++)
      alloc(i, 16'h0001);
    chk("t6_full", busy_mask, 32'hFFFF);
    chk("t6_ready", ready_mask, 0);
    chk("t6_ivalid", issue_valid, 0);
    alloc(0, '0);
    chk("t6_err", alloc_err, 1);
    tick();
    chk("t6_err_pulse", alloc_err, 0);
    chk("t6_busy_kept", busy_mask, 32'hFFFF);
    tick();
    tick();
    chk("t6_stall", stall_cnt, pc(15));
    chk("t6_icnt", issue_cnt, pc(5));
    cmp(2'b01, 0, 0);
    chk("t6_release", ready_mask, 32'hFFFE);
    chk("t6_iidx", issue_idx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
